randomizer_ctrl: RTL

RANDOMIZER_CTRL -- requirements
Module: randomizer_ctrl

---
 rtl/randomizer_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/randomizer_ctrl.sv
// Burst controller for a serial LFSR randomizer: loads the seed MSB first,
// then streams plaintext bits through it and registers the randomized result.
module randomizer_ctrl #(
  parameter int SEED_W = 15,
  parameter int LEN_W  = 12,
  parameter logic [SEED_W-1:0] DEFAULT_SEED = SEED_W'(15'h3715)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_default,
  input  logic [SEED_W-1:0] seed,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic             abort,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             rnd_enable,
  output logic             rnd_load,
  output logic             rnd_seed_bit,
  output logic             rnd_data_in,
  input  logic             rnd_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } state_e;

  localparam logic [3:0] LD_LAST = 4'(SEED_W - 1);

  state_e             state_q, state_d;
  logic [SEED_W-1:0]  seed_q, seed_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [3:0]         ld_cnt_q, ld_cnt_d;
  logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               out_bit_q, out_bit_d;
  logic               out_valid_q, out_valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      seed_q      <= '0;
      len_q       <= '0;
      ld_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      len_q       <= len_d;
      ld_cnt_q    <= ld_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    len_d        = len_q;
    ld_cnt_d     = ld_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    out_bit_d    = out_bit_q;
    out_valid_d  = 1'b0;
    in_ready     = 1'b0;
    busy         = (state_q != IDLE);
    done         = 1'b0;
    rnd_enable   = 1'b0;
    rnd_load     = 1'b0;
    rnd_seed_bit = 1'b0;
    rnd_data_in  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          seed_d    = use_default ? DEFAULT_SEED : seed;
          len_d     = burst_len;
          ld_cnt_d  = '0;
          bit_cnt_d = '0;
          state_d   = LOAD;
        end
      end

      LOAD: begin
        // Seed register shifts left so its MSB is always the bit on the wire.
        rnd_load     = 1'b1;
        rnd_enable   = 1'b1;
        rnd_seed_bit = seed_q[SEED_W-1];
        seed_d       = {seed_q[SEED_W-2:0], 1'b0};
        ld_cnt_d     = ld_cnt_q + 4'd1;
        if (abort) begin
          state_d = IDLE;
        end else if (ld_cnt_q == LD_LAST) begin
          state_d = (len_q == '0) ? DONE : STREAM;
        end
      end

      STREAM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rnd_enable  = 1'b1;
          rnd_data_in = in_bit;
          out_bit_d   = rnd_data_out;
          out_valid_d = 1'b1;
          bit_cnt_d   = bit_cnt_q + 1'b1;
          if (bit_cnt_d == len_q) begin
            state_d = DONE;
          end
        end
        // An accepted bit in the abort cycle is still delivered.
        if (abort) begin
          state_d = IDLE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;

endmodule
